// File: rtl/bids_n_pkg.sv
// Shared types for the N-bidder sealed-round auction controller.
// Opcodes, control/bid error codes and controller states.
package bids_n_pkg;

    typedef enum logic [3:0] {
        OP_NOP       = 4'd0,
        OP_UNLOCK    = 4'd1,
        OP_LOCK      = 4'd2,
        OP_LOAD      = 4'd3,
        OP_SETMASK   = 4'd4,
        OP_SETTIMER  = 4'd5,
        OP_SETCHARGE = 4'd6
    } opcode_e;

    typedef enum logic [2:0] {
        ERR_NONE               = 3'd0,
        ERR_BADKEY             = 3'd1,
        ERR_ALREADYUNLOCKED    = 3'd2,
        ERR_CSTARTWHENUNLOCKED = 3'd3,
        ERR_INVALID_OP         = 3'd4,
        ERR_DUPLICATEBIDS      = 3'd5
    } ctrl_err_e;

    typedef enum logic [1:0] {
        BE_NONE              = 2'd0,
        BE_INSUFFICIENTFUNDS = 2'd1,
        BE_INVALIDREQUEST    = 2'd2,
        BE_ROUNDINACTIVE     = 2'd3
    } bid_err_e;

    typedef enum logic [2:0] {
        ST_UNLOCKED  = 3'd0,
        ST_LOCKED    = 3'd1,
        ST_COOLDOWN  = 3'd2,
        ST_ROUND     = 3'd3,
        ST_ROUNDOVER = 3'd4
    } state_e;

    localparam int TIMER_RESET  = 15;
    localparam int CHARGE_RESET = 1;

endpackage

// File: rtl/bids_n_bid_max_select.sv
// Combinational N-way maximum with index; equal values resolve to the lowest index.
// valid is low when every input is zero (no winner).
module bid_max_select
    import bids_n_pkg::*;
#(
    parameter int NUM_BIDDERS = 4,
    parameter int DATA_W      = 32,
    parameter int IDX_W       = $clog2(NUM_BIDDERS)
) (
    input  logic [NUM_BIDDERS*DATA_W-1:0] vals,
    output logic [DATA_W-1:0]             max_val,
    output logic [IDX_W-1:0]              max_idx,
    output logic                          valid
);

    always_comb begin
        max_val = '0;
        max_idx = '0;
        // strict greater-than keeps the earliest index on ties
        for (int i = 0; i < NUM_BIDDERS; i++) begin
            if (vals[i*DATA_W +: DATA_W] > max_val) begin
                max_val = vals[i*DATA_W +: DATA_W];
                max_idx = IDX_W'(i);
            end
        end
        valid = (max_val != '0);
    end

endmodule

// File: rtl/bids_n.sv
// N-bidder sealed-round auction controller: host programs balances/mask/charge/cooldown,
// locks with a key, then bidders compete in rounds framed by c_start.
module bids_n
    import bids_n_pkg::*;
#(
    parameter int NUM_BIDDERS = 4,
    parameter int DATA_W      = 32,
    parameter int IDX_W       = $clog2(NUM_BIDDERS)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [3:0]                    c_op,
    input  logic [DATA_W-1:0]             c_data,
    input  logic [IDX_W-1:0]              c_idx,
    input  logic                          c_start,
    input  logic [NUM_BIDDERS-1:0]        bid,
    input  logic [NUM_BIDDERS-1:0]        retract,
    input  logic [NUM_BIDDERS*DATA_W-1:0] bid_amt,
    output logic [NUM_BIDDERS-1:0]        ack,
    output logic [NUM_BIDDERS*2-1:0]      bid_err,
    output logic [NUM_BIDDERS*DATA_W-1:0] balance,
    output logic [NUM_BIDDERS-1:0]        win,
    output logic                          ready,
    output logic [2:0]                    err,
    output logic                          round_over,
    output logic [DATA_W-1:0]             max_bid,
    output logic [IDX_W-1:0]              winner_idx
);

    state_e                   state_reg, state_next;
    ctrl_err_e                err_c;
    opcode_e                  op;
    logic [DATA_W-1:0]        key_reg, timer_reg, charge_reg, cnt_reg;
    logic [NUM_BIDDERS-1:0]   mask_reg;
    logic                     round_over_reg;
    logic [NUM_BIDDERS-1:0]   win_reg;
    logic [DATA_W-1:0]        max_bid_reg;
    logic [IDX_W-1:0]         winner_idx_reg;

    logic [NUM_BIDDERS-1:0]        eligible;
    logic [NUM_BIDDERS*DATA_W-1:0] last_bid_flat;
    logic                          dup;
    logic [DATA_W-1:0]             sel_max;
    logic [IDX_W-1:0]              sel_idx;
    logic                          sel_valid;
    logic                          ctrl_en, in_round, round_start, bad_unlock;

    assign op          = opcode_e'(c_op);
    assign ctrl_en     = (state_reg == ST_UNLOCKED) && !c_start;
    assign in_round    = (state_reg == ST_ROUND);
    assign round_start = (state_reg == ST_LOCKED) && c_start;
    assign bad_unlock  = (state_reg == ST_LOCKED) && !c_start &&
                         (op == OP_UNLOCK) && (c_data != key_reg);

    bid_max_select #(
        .NUM_BIDDERS(NUM_BIDDERS),
        .DATA_W     (DATA_W),
        .IDX_W      (IDX_W)
    ) u_max (
        .vals   (last_bid_flat),
        .max_val(sel_max),
        .max_idx(sel_idx),
        .valid  (sel_valid)
    );

    // equal amounts among bids that will actually be accepted this cycle
    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < NUM_BIDDERS; i++) begin
            for (int j = i + 1; j < NUM_BIDDERS; j++) begin
                if (eligible[i] && eligible[j] &&
                    (bid_amt[i*DATA_W +: DATA_W] == bid_amt[j*DATA_W +: DATA_W]))
                    dup = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        err_c      = ERR_NONE;
        ready      = 1'b1;
        case (state_reg)
            ST_UNLOCKED: begin
                if (c_start) begin
                    err_c = ERR_CSTARTWHENUNLOCKED;
                end else begin
                    case (op)
                        OP_NOP, OP_SETMASK, OP_SETTIMER, OP_SETCHARGE: err_c = ERR_NONE;
                        OP_LOCK:   state_next = ST_LOCKED;
                        OP_UNLOCK: err_c = ERR_ALREADYUNLOCKED;
                        OP_LOAD:   if (int'(c_idx) >= NUM_BIDDERS) err_c = ERR_INVALID_OP;
                        default:   err_c = ERR_INVALID_OP;
                    endcase
                end
            end
            ST_LOCKED: begin
                if (c_start)
                    state_next = ST_ROUND;
                else if (op == OP_UNLOCK)
                    state_next = (c_data == key_reg) ? ST_UNLOCKED : ST_COOLDOWN;
            end
            ST_COOLDOWN: begin
                err_c = ERR_BADKEY;
                ready = 1'b0;
                // a loaded count of N yields N cycles here; zero still yields one
                if (cnt_reg <= DATA_W'(1))
                    state_next = ST_LOCKED;
            end
            ST_ROUND: begin
                if (dup)
                    err_c = ERR_DUPLICATEBIDS;
                if (!c_start)
                    state_next = ST_ROUNDOVER;
            end
            ST_ROUNDOVER: begin
                ready      = 1'b0;
                state_next = ST_LOCKED;
            end
            default: state_next = ST_UNLOCKED;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_UNLOCKED;
            key_reg        <= '0;
            timer_reg      <= DATA_W'(TIMER_RESET);
            charge_reg     <= DATA_W'(CHARGE_RESET);
            mask_reg       <= '1;
            cnt_reg        <= '0;
            round_over_reg <= 1'b0;
            win_reg        <= '0;
            max_bid_reg    <= '0;
            winner_idx_reg <= '0;
        end else begin
            state_reg      <= state_next;
            round_over_reg <= 1'b0;
            if (ctrl_en) begin
                case (op)
                    OP_LOCK:      key_reg    <= c_data;
                    OP_SETMASK:   mask_reg   <= c_data[NUM_BIDDERS-1:0];
                    OP_SETTIMER:  timer_reg  <= c_data;
                    OP_SETCHARGE: charge_reg <= c_data;
                    default: ;
                endcase
            end
            if (bad_unlock)
                cnt_reg <= timer_reg;
            else if ((state_reg == ST_COOLDOWN) && (cnt_reg != '0))
                cnt_reg <= cnt_reg - DATA_W'(1);
            if (round_start) begin
                win_reg        <= '0;
                max_bid_reg    <= '0;
                winner_idx_reg <= '0;
            end
            if (state_reg == ST_ROUNDOVER) begin
                round_over_reg <= 1'b1;
                if (sel_valid) begin
                    win_reg        <= NUM_BIDDERS'(1) << sel_idx;
                    max_bid_reg    <= sel_max;
                    winner_idx_reg <= sel_idx;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BIDDERS; gi++) begin : g_bidder
            logic [DATA_W-1:0] amt, bal_reg, last_bid_reg;
            logic              funded, ack_reg;
            bid_err_e          bid_err_reg;

            assign amt    = bid_amt[gi*DATA_W +: DATA_W];
            // one extra bit so amount + charge cannot wrap past the balance
            assign funded = ({1'b0, amt} + {1'b0, charge_reg}) <= {1'b0, bal_reg};
            assign eligible[gi] = bid[gi] && mask_reg[gi] && funded;

            assign balance[gi*DATA_W +: DATA_W]       = bal_reg;
            assign last_bid_flat[gi*DATA_W +: DATA_W] = last_bid_reg;
            assign ack[gi]                            = ack_reg;
            assign bid_err[gi*2 +: 2]                 = bid_err_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    bal_reg      <= '0;
                    last_bid_reg <= '0;
                    ack_reg      <= 1'b0;
                    bid_err_reg  <= BE_NONE;
                end else begin
                    ack_reg     <= 1'b0;
                    bid_err_reg <= BE_NONE;
                    if (in_round) begin
                        if (bid[gi]) begin
                            if (!mask_reg[gi]) begin
                                bid_err_reg <= BE_INVALIDREQUEST;
                            end else if (!funded) begin
                                bid_err_reg <= BE_INSUFFICIENTFUNDS;
                            end else begin
                                bal_reg      <= bal_reg - charge_reg;
                                last_bid_reg <= amt;
                                ack_reg      <= 1'b1;
                            end
                        end else if (retract[gi]) begin
                            last_bid_reg <= '0;
                            ack_reg      <= 1'b1;
                        end
                    end else begin
                        if (bid[gi] || retract[gi])
                            bid_err_reg <= BE_ROUNDINACTIVE;
                        if (round_start)
                            last_bid_reg <= '0;
                        if ((state_reg == ST_ROUNDOVER) && sel_valid && (sel_idx == IDX_W'(gi)))
                            bal_reg <= bal_reg - last_bid_reg;
                        if (ctrl_en && (op == OP_LOAD) && (int'(c_idx) == gi))
                            bal_reg <= c_data;
                    end
                end
            end
        end
    endgenerate

    assign err        = err_c;
    assign round_over = round_over_reg;
    assign win        = win_reg;
    assign max_bid    = max_bid_reg;
    assign winner_idx = winner_idx_reg;

endmodule

// File: tb/tb_bids_n.sv
// Scoreboard bench for bids_n: a behavioural auction model predicts every cycle's outputs,
// a negedge monitor compares them and checks each round result as round_over is raised.
module tb_bids_n;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int IW = 2;
    localparam int M_UNL = 0, M_LCK = 1, M_COOL = 2, M_RND = 3, M_ROVER = 4;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [3:0]     c_op;
    logic [W-1:0]   c_data;
    logic [IW-1:0]  c_idx;
    logic           c_start;
    logic [N-1:0]   bid, retract;
    logic [N*W-1:0] bid_amt;
    logic [N-1:0]   ack;
    logic [2*N-1:0] bid_err;
    logic [N*W-1:0] balance;
    logic [N-1:0]   win;
    logic           ready;
    logic [2:0]     err;
    logic           round_over;
    logic [W-1:0]   max_bid;
    logic [IW-1:0]  winner_idx;

    always #5 clk = ~clk;

    bids_n #(.NUM_BIDDERS(N), .DATA_W(W), .IDX_W(IW)) dut (
        .clk(clk), .reset_n(reset_n), .c_op(c_op), .c_data(c_data), .c_idx(c_idx),
        .c_start(c_start), .bid(bid), .retract(retract), .bid_amt(bid_amt),
        .ack(ack), .bid_err(bid_err), .balance(balance), .win(win), .ready(ready),
        .err(err), .round_over(round_over), .max_bid(max_bid), .winner_idx(winner_idx)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0] err; logic ready; logic [N-1:0] ack; logic [2*N-1:0] berr;
        logic [N*W-1:0] bal; logic rover; logic [N-1:0] win; logic [W-1:0] maxb; logic [IW-1:0] idx;
    } obs_t;
    typedef struct { logic [N-1:0] win; logic [W-1:0] maxb; logic [IW-1:0] idx; } res_t;
    obs_t exp_q[$];
    res_t res_q[$];

    // behavioural model
    int           mode, cool_left;
    logic [W-1:0] m_bal[N], m_last[N], amt[N];
    logic         fund[N];
    logic [W-1:0] m_key, m_timer, m_charge, m_max;
    logic [N-1:0] m_mask, m_ack, m_win;
    logic [2*N-1:0] m_berr;
    logic         m_rover;
    logic [IW-1:0] m_idx;
    logic [2:0]   cyc_err;
    logic         cyc_ready;

    task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        obs_t e;
        res_t r;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp("err", err, e.err);
            cmp("ready", ready, e.ready);
            cmp("ack", ack, e.ack);
            cmp("bid_err", bid_err, e.berr);
            cmp("balance", balance, e.bal);
            cmp("round_over", round_over, e.rover);
            cmp("win", win, e.win);
            cmp("max_bid", max_bid, e.maxb);
            cmp("winner_idx", winner_idx, e.idx);
        end
        if (round_over === 1'b1) begin
            if (res_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL round_result: unexpected round_over win=%b", win);
            end else begin
                r = res_q.pop_front();
                cmp("result_win", win, r.win);
                cmp("result_max", max_bid, r.maxb);
                cmp("result_idx", winner_idx, r.idx);
                $display("round result win=%b max_bid=%0d winner_idx=%0d", win, max_bid, winner_idx);
            end
        end
    end

    task automatic model_reset();
        mode = M_UNL; cool_left = 0;
        for (int i = 0; i < N; i++) begin m_bal[i] = '0; m_last[i] = '0; end
        m_key = '0; m_timer = 32'd15; m_charge = 32'd1; m_mask = '1;
        m_ack = '0; m_berr = '0; m_rover = 1'b0; m_win = '0; m_max = '0; m_idx = '0;
    endtask

    task automatic model_step(input logic [3:0] op, input logic [W-1:0] d, input int idx,
                              input logic cs, input logic [N-1:0] b, input logic [N-1:0] r);
        logic [N-1:0] n_ack;
        logic [2*N-1:0] n_berr;
        logic [W-1:0] best;
        int bi;
        res_t rr;
        n_ack = '0; n_berr = '0;
        for (int i = 0; i < N; i++) begin
            if (mode == M_RND) begin
                if (b[i]) begin
                    if (!m_mask[i]) n_berr[2*i +: 2] = 2'd2;
                    else if (!fund[i]) n_berr[2*i +: 2] = 2'd1;
                    else begin m_bal[i] = m_bal[i] - m_charge; m_last[i] = amt[i]; n_ack[i] = 1'b1; end
                end else if (r[i]) begin
                    m_last[i] = '0; n_ack[i] = 1'b1;
                end
            end else if (b[i] || r[i]) begin
                n_berr[2*i +: 2] = 2'd3;
            end
        end
        m_rover = (mode == M_ROVER);
        case (mode)
            M_UNL: if (!cs) begin
                case (op)
                    4'd2: begin m_key = d; mode = M_LCK; end
                    4'd3: if (idx < N) m_bal[idx] = d;
                    4'd4: m_mask = d[N-1:0];
                    4'd5: m_timer = d;
                    4'd6: m_charge = d;
                    default: ;
                endcase
            end
            M_LCK: begin
                if (cs) begin
                    for (int i = 0; i < N; i++) m_last[i] = '0;
                    m_win = '0; m_max = '0; m_idx = '0; mode = M_RND;
                end else if (op == 4'd1) begin
                    if (d == m_key) mode = M_UNL;
                    else begin mode = M_COOL; cool_left = (m_timer == 0) ? 1 : int'(m_timer); end
                end
            end
            M_COOL: begin
                cool_left--;
                if (cool_left == 0) mode = M_LCK;
            end
            M_RND: if (!cs) mode = M_ROVER;
            default: begin
                best = '0; bi = 0;
                for (int i = 0; i < N; i++) if (m_last[i] > best) begin best = m_last[i]; bi = i; end
                if (best != 0) begin
                    m_win = '0; m_win[bi] = 1'b1; m_max = best; m_idx = IW'(bi);
                    m_bal[bi] = m_bal[bi] - best;
                end
                rr.win = m_win; rr.maxb = m_max; rr.idx = m_idx;
                res_q.push_back(rr);
                mode = M_LCK;
            end
        endcase
        m_ack = n_ack; m_berr = n_berr;
    endtask

    task automatic drive(input logic rst, input logic [3:0] op, input logic [W-1:0] d, input int idx,
                         input logic cs, input logic [N-1:0] b, input logic [N-1:0] r);
        obs_t e;
        logic dup;
        reset_n = rst; c_op = op; c_data = d; c_idx = IW'(idx); c_start = cs; bid = b; retract = r;
        if (!rst) model_reset();
        for (int i = 0; i < N; i++) begin
            bid_amt[i*W +: W] = amt[i];
            fund[i] = (longint'(amt[i]) + longint'(m_charge)) <= longint'(m_bal[i]);
        end
        dup = 1'b0;
        for (int i = 0; i < N; i++)
            for (int j = i + 1; j < N; j++)
                if (b[i] && b[j] && m_mask[i] && m_mask[j] && fund[i] && fund[j] && amt[i] == amt[j])
                    dup = 1'b1;
        e.ready = !(mode == M_COOL || mode == M_ROVER);
        case (mode)
            M_UNL: begin
                if (cs) e.err = 3'd3;
                else if (op == 4'd1) e.err = 3'd2;
                else if (op == 4'd3) e.err = (idx >= N) ? 3'd4 : 3'd0;
                else if (op == 4'd0 || op == 4'd2 || op == 4'd4 || op == 4'd5 || op == 4'd6) e.err = 3'd0;
                else e.err = 3'd4;
            end
            M_COOL:  e.err = 3'd1;
            M_RND:   e.err = dup ? 3'd5 : 3'd0;
            default: e.err = 3'd0;
        endcase
        e.ack = m_ack; e.berr = m_berr; e.rover = m_rover; e.win = m_win; e.maxb = m_max; e.idx = m_idx;
        for (int i = 0; i < N; i++) e.bal[i*W +: W] = m_bal[i];
        exp_q.push_back(e);
        if (rst) model_step(op, d, idx, cs, b, r);
        #3;
        cyc_err = err; cyc_ready = ready;
        @(posedge clk); #1;
        $display("txn rst_n=%0b op=%0d data=%0h idx=%0d cs=%0b bid=%b ret=%b -> err=%0d ack=%b bid_err=%b",
                 rst, op, d, idx, cs, b, r, cyc_err, ack, bid_err);
    endtask

    task automatic ctl(input logic [3:0] op, input logic [W-1:0] d, input int idx);
        drive(1'b1, op, d, idx, 1'b0, '0, '0);
    endtask

    task automatic idle(input logic cs);
        drive(1'b1, 4'd0, '0, 0, cs, '0, '0);
    endtask

    task automatic clr_amt();
        for (int i = 0; i < N; i++) amt[i] = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] key;
        int n;
        reset_n = 1'b0; c_op = '0; c_data = '0; c_idx = '0; c_start = 1'b0;
        bid = '0; retract = '0; bid_amt = '0;
        clr_amt();
        model_reset();
        @(posedge clk); #1;
        drive(1'b0, 4'd0, '0, 0, 1'b0, '0, '0);
        drive(1'b0, 4'd0, '0, 0, 1'b0, '0, '0);
        cmp("reset_ready", ready, 1'b1);
        cmp("reset_balance", balance, '0);
        cmp("reset_win", win, '0);

        // basic round
        ctl(4'd3, 32'd100, 0); ctl(4'd3, 32'd50, 1); ctl(4'd2, 32'hA5, 0);
        idle(1'b1);
        amt[0] = 32'd40; amt[1] = 32'd30;
        drive(1'b1, 4'd0, '0, 0, 1'b1, 4'b0011, 4'b0000);
        cmp("basic_ack", ack, 4'b0011);
        clr_amt(); idle(1'b0); idle(1'b0);
        cmp("basic_round_over", round_over, 1'b1);
        cmp("basic_win", win, 4'b0001);
        cmp("basic_max", max_bid, 32'd40);
        cmp("basic_bal0", balance[31:0], 32'd59);
        cmp("basic_bal1", balance[63:32], 32'd49);

        // tie between bidders 1 and 2
        ctl(4'd1, 32'hA5, 0); ctl(4'd3, 32'd50, 2); ctl(4'd2, 32'hA5, 0);
        idle(1'b1);
        amt[1] = 32'd20; amt[2] = 32'd20;
        drive(1'b1, 4'd0, '0, 0, 1'b1, 4'b0110, 4'b0000);
        cmp("tie_err", cyc_err, 3'd5);
        clr_amt(); idle(1'b0); idle(1'b0);
        cmp("tie_winner_idx", winner_idx, 2'd1);
        cmp("tie_max", max_bid, 32'd20);

        // insufficient funds boundary
        ctl(4'd1, 32'hA5, 0); ctl(4'd3, 32'd10, 3); ctl(4'd2, 32'hA5, 0);
        idle(1'b1);
        amt[3] = 32'd10;
        drive(1'b1, 4'd0, '0, 0, 1'b1, 4'b1000, 4'b0000);
        cmp("funds_berr", bid_err[7:6], 2'd1);
        cmp("funds_ack", ack[3], 1'b0);
        cmp("funds_bal_kept", balance[127:96], 32'd10);
        amt[3] = 32'd9;
        drive(1'b1, 4'd0, '0, 0, 1'b1, 4'b1000, 4'b0000);
        cmp("funds_ok_ack", ack[3], 1'b1);
        cmp("funds_ok_bal", balance[127:96], 32'd9);
        clr_amt(); idle(1'b0); idle(1'b0);

        // masked bidder 0
        ctl(4'd1, 32'hA5, 0); ctl(4'd4, 32'b1110, 0); ctl(4'd3, 32'd100, 0); ctl(4'd2, 32'hA5, 0);
        idle(1'b1);
        amt[0] = 32'd50; amt[1] = 32'd5;
        drive(1'b1, 4'd0, '0, 0, 1'b1, 4'b0011, 4'b0000);
        cmp("mask_berr", bid_err[1:0], 2'd2);
        clr_amt(); idle(1'b0); idle(1'b0);
        cmp("mask_win", win, 4'b0010);

        // wrong key cooldown
        ctl(4'd1, 32'hA5, 0); ctl(4'd5, 32'd3, 0); ctl(4'd4, 32'hF, 0); ctl(4'd2, 32'hA5, 0);
        ctl(4'd1, 32'h11, 0);
        for (int k = 0; k < 3; k++) begin
            idle(1'b0);
            cmp("cool_err", cyc_err, 3'd1);
            cmp("cool_ready", cyc_ready, 1'b0);
        end
        idle(1'b0);
        cmp("cool_done_err", cyc_err, 3'd0);
        cmp("cool_done_ready", cyc_ready, 1'b1);
        ctl(4'd1, 32'hA5, 0);
        ctl(4'd1, 32'h0, 0);
        cmp("unlocked_again", cyc_err, 3'd2);

        // reset inside a round
        ctl(4'd3, 32'd30, 0); ctl(4'd2, 32'hA5, 0);
        idle(1'b1);
        amt[0] = 32'd10;
        drive(1'b1, 4'd0, '0, 0, 1'b1, 4'b0001, 4'b0000);
        cmp("rst_pre_ack", ack[0], 1'b1);
        clr_amt();
        drive(1'b0, 4'd0, '0, 0, 1'b0, '0, '0);
        cmp("rst_balance", balance, '0);
        idle(1'b0);
        cmp("rst_no_round_over", round_over, 1'b0);
        ctl(4'd1, 32'h0, 0);
        cmp("rst_unlocked", cyc_err, 3'd2);

        // randomized sessions
        for (int it = 0; it < 30; it++) begin
            repeat ($urandom_range(2, 6)) begin
                case ($urandom_range(0, 7))
                    0: ctl(4'd3, $urandom_range(0, 120), $urandom_range(0, N-1));
                    1: ctl(4'd4, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : 15, 0);
                    2: ctl(4'd6, $urandom_range(0, 3), 0);
                    3: ctl(4'd5, $urandom_range(0, 4), 0);
                    4: ctl(4'($urandom_range(7, 15)), $urandom, 0);
                    5: ctl(4'd1, 32'h0, 0);
                    6: drive(1'b1, 4'd3, 32'd77, 0, 1'b1, '0, '0);
                    default: ctl(4'd3, $urandom_range(20, 200), $urandom_range(0, N-1));
                endcase
            end
            key = $urandom;
            ctl(4'd2, key, 0);
            ctl(4'd3, 32'd5, 0);
            if ($urandom_range(0, 3) == 0) begin
                ctl(4'd1, key ^ 32'd1, 0);
                n = 0;
                while (ready === 1'b0 && n < 20) begin idle(1'b0); n++; end
                cmp("cooldown_bound", ready, 1'b1);
            end
            drive(1'b1, 4'd0, '0, 0, 1'b1, 4'($urandom_range(0, 15)), '0);
            repeat ($urandom_range(1, 5)) begin
                for (int i = 0; i < N; i++) amt[i] = 32'($urandom_range(0, 8) * 5);
                drive(1'b1, 4'd0, '0, 0, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            end
            if ($urandom_range(0, 7) == 0) begin
                drive(1'b0, 4'd0, '0, 0, 1'b0, '0, '0);
                clr_amt();
                continue;
            end
            for (int i = 0; i < N; i++) amt[i] = 32'($urandom_range(0, 8) * 5);
            drive(1'b1, 4'd0, '0, 0, 1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            drive(1'b1, 4'd0, '0, 0, 1'b0, 4'($urandom_range(0, 15)), '0);
            clr_amt();
            ctl(4'd1, key, 0);
        end

        idle(1'b0); idle(1'b0);
        @(negedge clk); #1;
        cmp("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        cmp("results_drained", 32'(res_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bids_n.md
Name: bids_n

Overview:
N-bidder sealed-round auction controller, the parametrised successor of the three-bidder unit. A host control port programs balances, mask, bid charge and cooldown, then locks the unit with a key. Bidders bid in rounds while c_start is held; at round end one winner is chosen with deterministic tie-break and charged. Flat vector ports replace the fixed X/Y/Z interface.

Parameters:
NUM_BIDDERS, 4, number of bidder channels (2..16)
DATA_W, 32, width of balances, bids, key, timer, charge
IDX_W, $clog2(NUM_BIDDERS), bidder index width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
c_op  in  4  control opcode
c_data  in  DATA_W  control operand
c_idx  in  IDX_W  target bidder for LOAD
c_start  in  1  round active while high
bid  in  NUM_BIDDERS  per-bidder bid request
retract  in  NUM_BIDDERS  per-bidder retract request
bid_amt  in  NUM_BIDDERS*DATA_W  packed bid amounts, bidder i at [i*DATA_W +: DATA_W]
ack  out  NUM_BIDDERS  request accepted (registered)
bid_err  out  NUM_BIDDERS*2  per-bidder error code (registered)
balance  out  NUM_BIDDERS*DATA_W  current balances
win  out  NUM_BIDDERS  one-hot winner, held until next round start
ready  out  1  unit accepts control/round input
err  out  3  control error code
round_over  out  1  one-cycle pulse at result
max_bid  out  DATA_W  winning amount, held
winner_idx  out  IDX_W  winning index, held

Behaviour:
- Clock clk; reset is asynchronous and active-low on reset_n.
- Reset: state UNLOCKED; balances 0, last bids 0, mask all ones, timer_val 15, key 0, charge 1. Outputs: ack/win/bid_err 0, err NOERROR, round_over 0, max_bid 0, winner_idx 0, ready 1.
- Reset mid-round aborts the round with no charge applied.
- States: UNLOCKED, LOCKED, COOLDOWN, ROUND, ROUNDOVER.
- UNLOCKED accepts these opcodes:
  - NO_OP=0.
  - LOCK=2: key<=c_data; ->LOCKED next cycle.
  - LOAD=3: balance[c_idx]<=c_data; ignored if c_idx>=NUM_BIDDERS, err INVALID_OP.
  - SETMASK=4: low NUM_BIDDERS bits of c_data.
  - SETTIMER=5, SETBIDCHARGE=6.
- UNLOCKED errors (err is combinational, same cycle): UNLOCK=1 gives ALREADYUNLOCKED; other opcodes give INVALID_OP; c_start gives CSTARTWHENUNLOCKED, which takes priority and suppresses the opcode.
- LOCKED:
  - c_start -> ROUND, clears all last bids, win, max_bid and winner_idx.
  - Otherwise UNLOCK with c_data==key -> UNLOCKED.
  - UNLOCK with a wrong key -> COOLDOWN, counter loaded with timer_val.
  - Other opcodes are ignored.
- COOLDOWN: err=BADKEY and ready=0; all inputs ignored. Counter decrements each cycle; at 0 -> LOCKED. timer_val=0 gives a single COOLDOWN cycle.
- ROUND: each bidder is evaluated independently every cycle; responses appear one cycle later.
  - Masked bidder with bid: bid_err=INVALIDREQUEST(2), ack 0.
  - Sufficient-funds rule: bid_amt+charge <= balance, computed at DATA_W+1 bits (no wrap). On failure: INSUFFICIENTFUNDS(1), ack 0.
  - Accepted bid: balance -= charge; last_bid <= bid_amt; ack 1; NOBIDERROR(0).
  - retract without bid: last_bid<=0, ack 1, no charge. bid and retract together: bid wins.
  - A bid or retract outside ROUND gives ROUNDINACTIVE(3), ack 0.
  - err=DUPLICATEBIDS when two or more eligible (unmasked, funded) bids in the same cycle carry equal amounts. Both are still accepted.
- c_start low in ROUND -> ROUNDOVER, with ready=0 for one cycle.
  - Winner = maximum last_bid, ties to the lowest index; all zero means no winner.
  - Next cycle: round_over=1; if there is a winner, win one-hot, max_bid and winner_idx set, winner balance -= last_bid. Then -> LOCKED.
- Error codes: NOERROR=0, BADKEY=1, ALREADYUNLOCKED=2, CSTARTWHENUNLOCKED=3, INVALID_OP=4, DUPLICATEBIDS=5.

Decomposition:
- Package bids_n_pkg: opcode enum, ctrl error enum, bid error enum, state enum.
- Sub-module bid_max_select: combinational NUM_BIDDERS-way max with index and valid flag, lowest-index tie-break, parametrised on NUM_BIDDERS and DATA_W.

Test Plan:
- Reset, LOAD idx0=100 and idx1=50, LOCK key=0xA5, c_start. Bidder0 bids 40, bidder1 bids 30, drop c_start -> round_over pulse, win=0001, max_bid=40, balance0=100-1-40=59, balance1=49.
- Tie: bidders 1 and 2 both bid 20 in one cycle -> err=DUPLICATEBIDS that cycle; winner_idx=1.
- Insufficient funds: balance 10, charge 1, bid 10 -> bid_err=1, ack 0, balance unchanged; bid 9 -> ack 1, balance 9.
- Mask 0b1110, bidder0 bids -> bid_err=2; bidder0 never wins.
- LOCKED, UNLOCK with 0x11 and SETTIMER=3 beforehand -> exactly 3 COOLDOWN cycles with err=BADKEY, ready 0, then LOCKED. UNLOCK 0xA5 -> UNLOCKED.
- reset_n low during ROUND after accepted bid -> all balances 0, state UNLOCKED, no round_over.
